// File: rtl/spi_cmd_decoder_pkg.sv
// spi_cmd_decoder_pkg: opcodes, frame lengths and FSM encoding for the SPI note-command decoder
package spi_cmd_decoder_pkg;
    localparam logic [7:0] OP_NOTE_ON  = 8'h01;
    localparam logic [7:0] OP_NOTE_OFF = 8'h02;
    localparam logic [7:0] OP_RETUNE   = 8'h03;
    localparam logic [2:0] LEN_NOTE_ON  = 3'd7;
    localparam logic [2:0] LEN_NOTE_OFF = 3'd2;
    localparam logic [2:0] LEN_RETUNE   = 3'd6;
    typedef enum logic [2:0] {ST_IDLE, ST_OPCODE, ST_PAYLOAD, ST_DONE, ST_SKIP} state_t;
    // Zero marks an opcode the decoder does not understand
    function automatic logic [2:0] frame_len(input logic [7:0] op);
        return op == OP_NOTE_ON ? LEN_NOTE_ON : op == OP_NOTE_OFF ? LEN_NOTE_OFF :
               op == OP_RETUNE ? LEN_RETUNE : 3'd0;
    endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall detection on the synchronized level
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
        end
    end
    assign level = sync[STAGES-1];
    assign rise  = (level ^ prev) & level;
    assign fall  = (level ^ prev) & prev;
endmodule

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: SPI mode-0 slave decoding note commands into the voice_controller command bus
module spi_cmd_decoder
    import spi_cmd_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_CNT_W = 7
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_sclk,
    input  logic        i_cs_n,
    input  logic        i_mosi,
    output logic        o_miso,
    output logic        o_SPI_flag_dds,
    output logic        o_SPI_flag_adsr,
    output logic [7:0]  o_SPI_voice_index,
    output logic [31:0] o_SPI_tuning_code,
    output logic [7:0]  o_SPI_velocity,
    output logic        o_SPI_note_status,
    output logic        o_frame_err
);
    localparam int STW = FRAME_CNT_W + 1;
    logic sclk_level, sclk_rise, sclk_fall, cs_level, cs_rise, cs_fall, mosi_level, mosi_rise, mosi_fall;
    logic unused_sync;
    state_t state, state_nxt;
    logic [2:0] bit_cnt, byte_cnt, len;
    logic [7:0] shreg, opcode, stg_voice, stg_vel, byte_in, nxt_voice, nxt_vel;
    logic [31:0] stg_tune, nxt_tune;
    logic byte_done, last_byte, op_valid, frame_done, abort, err_now, err_sticky, miso_act, miso_q;
    logic [FRAME_CNT_W-1:0] good_cnt;
    logic [STW-1:0] status_sr;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (.clk(i_clk), .rst_n(i_reset), .din(i_sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (.clk(i_clk), .rst_n(i_reset), .din(i_cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (.clk(i_clk), .rst_n(i_reset), .din(i_mosi),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall));
    assign unused_sync = ^{sclk_level, mosi_rise, mosi_fall};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = cs_rise ? ST_IDLE :
                    cs_fall ? ST_OPCODE :
                    state == ST_DONE ? ST_OPCODE :
                    (byte_done && state == ST_OPCODE) ? (op_valid ? ST_PAYLOAD : ST_SKIP) :
                    frame_done ? ST_DONE : state;
    end

    // The next staging value already includes the byte completing this cycle, so the
    // final byte of a frame can go straight to the outputs.
    always_comb begin
        byte_in    = {shreg[6:0], mosi_level};
        byte_done  = sclk_rise && bit_cnt == 3'd7 && (state == ST_OPCODE || state == ST_PAYLOAD);
        op_valid   = frame_len(byte_in) != 3'd0;
        len        = frame_len(opcode);
        last_byte  = state == ST_PAYLOAD && byte_cnt == len - 3'd1;
        frame_done = byte_done && last_byte && !cs_rise;
        abort      = cs_rise && (state == ST_PAYLOAD || (state == ST_OPCODE && bit_cnt != 3'd0));
        err_now    = abort || (byte_done && state == ST_OPCODE && !op_valid);
        nxt_voice  = byte_cnt == 3'd1 ? byte_in : stg_voice;
        nxt_tune   = (byte_cnt >= 3'd2 && byte_cnt <= 3'd5) ? {stg_tune[23:0], byte_in} : stg_tune;
        nxt_vel    = byte_cnt == 3'd6 ? byte_in : stg_vel;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            bit_cnt           <= '0;
            byte_cnt          <= '0;
            shreg             <= '0;
            opcode            <= '0;
            stg_voice         <= '0;
            stg_tune          <= '0;
            stg_vel           <= '0;
            o_SPI_flag_dds    <= 1'b0;
            o_SPI_flag_adsr   <= 1'b0;
            o_SPI_voice_index <= '0;
            o_SPI_tuning_code <= '0;
            o_SPI_velocity    <= '0;
            o_SPI_note_status <= 1'b0;
            o_frame_err       <= 1'b0;
        end else begin
            o_SPI_flag_dds  <= frame_done && opcode != OP_NOTE_OFF;
            o_SPI_flag_adsr <= frame_done && opcode != OP_RETUNE;
            o_frame_err     <= err_now;
            if (cs_fall) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (sclk_rise && (state == ST_OPCODE || state == ST_PAYLOAD)) begin
                shreg   <= byte_in;
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_done) byte_cnt <= last_byte ? 3'd0 : byte_cnt + 3'd1;
            end
            if (byte_done && state == ST_OPCODE) begin
                opcode    <= byte_in;
                stg_voice <= '0;
                stg_tune  <= '0;
                stg_vel   <= '0;
            end else if (byte_done) begin
                stg_voice <= nxt_voice;
                stg_tune  <= nxt_tune;
                stg_vel   <= nxt_vel;
            end
            if (frame_done) begin
                o_SPI_voice_index <= nxt_voice;
                if (opcode != OP_NOTE_OFF) o_SPI_tuning_code <= nxt_tune;
                if (opcode == OP_NOTE_ON) o_SPI_velocity <= nxt_vel;
                if (opcode != OP_RETUNE) o_SPI_note_status <= opcode == OP_NOTE_ON;
            end
        end
    end

    // Status byte goes out only during the first byte after CS falls
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            good_cnt   <= '0;
            err_sticky <= 1'b0;
            status_sr  <= '0;
            miso_q     <= 1'b0;
            miso_act   <= 1'b0;
        end else begin
            good_cnt   <= state == ST_DONE ? good_cnt + 1'b1 : good_cnt;
            err_sticky <= o_frame_err ? 1'b1 : cs_fall ? 1'b0 : err_sticky;
            if (cs_fall) begin
                status_sr <= {err_sticky, good_cnt};
                miso_q    <= err_sticky;
                miso_act  <= 1'b1;
            end else begin
                if (sclk_fall) begin
                    miso_q    <= miso_act & status_sr[STW-2];
                    status_sr <= status_sr << 1;
                end
                if (byte_done || cs_rise) miso_act <= 1'b0;
            end
        end
    end

    assign o_miso = miso_q & ~cs_level;
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder: table vectors, corner sequences and random frames checked against a frame-level model
module tb_spi_cmd_decoder;
    localparam int HALF = 60;
    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic dds; logic adsr; logic [7:0] voice; logic [31:0] tune; logic [7:0] vel; logic ns;
    } ev_t;
    typedef struct {
        logic [111:0] bytes; int n; int cut; int n_ev; int n_err;
        logic [7:0] voice; logic [31:0] tune; logic [7:0] vel; logic ns; logic [7:0] miso;
    } vec_t;

    logic clk, rst_n, sclk, cs_n, mosi, miso, dds, adsr, ns, ferr;
    logic [7:0] voice, vel;
    logic [31:0] tune;
    int tests = 0, fails = 0, err_cnt = 0;
    ev_t got_q[$], exp_q[$];
    int exp_err;
    logic [7:0] exp_miso;
    logic [7:0] m_voice, m_vel;
    logic [31:0] m_tune;
    logic m_ns, m_sticky;
    int m_good;

    spi_cmd_decoder dut (
        .i_clk(clk), .i_reset(rst_n), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi), .o_miso(miso),
        .o_SPI_flag_dds(dds), .o_SPI_flag_adsr(adsr), .o_SPI_voice_index(voice),
        .o_SPI_tuning_code(tune), .o_SPI_velocity(vel), .o_SPI_note_status(ns), .o_frame_err(ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dds || adsr) got_q.push_back({dds, adsr, voice, tune, vel, ns});
        if (ferr) err_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_voice = '0; m_tune = '0; m_vel = '0; m_ns = 1'b0; m_good = 0; m_sticky = 1'b0;
    endtask

    // Parses one CS window as a stream of frames and predicts strobes, errors and the status byte
    task automatic model_cs(input bq_t q, input int cut);
        int nc, pos, len;
        bit skipped;
        logic [7:0] op;
        exp_q.delete();
        exp_err = 0;
        exp_miso = {m_sticky, 7'(m_good % 128)};
        m_sticky = 1'b0;
        nc = cut >= 0 ? q.size() - 1 : q.size();
        pos = 0;
        skipped = 0;
        while (pos < nc && !skipped && exp_err == 0) begin
            op = q[pos];
            len = op == 8'h01 ? 7 : op == 8'h02 ? 2 : op == 8'h03 ? 6 : 0;
            if (len == 0) begin
                exp_err++;
                skipped = 1;
            end else if (pos + len > nc) begin
                exp_err++;
            end else begin
                m_voice = q[pos+1];
                if (op != 8'h02) m_tune = {q[pos+2], q[pos+3], q[pos+4], q[pos+5]};
                if (op == 8'h01) m_vel = q[pos+6];
                if (op != 8'h03) m_ns = op == 8'h01;
                m_good++;
                exp_q.push_back({op != 8'h02, op != 8'h03, m_voice, m_tune, m_vel, m_ns});
                pos += len;
            end
        end
        if (exp_err == 0 && cut > 0) exp_err++;
        if (exp_err != 0) m_sticky = 1'b1;
    endtask

    task automatic xfer_byte(input logic [7:0] b, input int nb, output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nb; i++) begin
            mosi = b[7-i];
            #HALF;
            sclk = 1'b1;
            mi[7-i] = miso;
            #HALF;
            sclk = 1'b0;
        end
    endtask

    task automatic run_cs(input bq_t q, input int cut, output logic [7:0] mi0);
        int base, e0;
        logic [7:0] mi;
        model_cs(q, cut);
        base = got_q.size();
        e0 = err_cnt;
        mi0 = '0;
        cs_n = 1'b0;
        #HALF;
        foreach (q[i]) begin
            xfer_byte(q[i], (cut >= 0 && i == q.size() - 1) ? cut : 8, mi);
            if (i == 0) mi0 = mi;
        end
        #HALF;
        cs_n = 1'b1;
        #(4*HALF);
        check("ev_count", 64'(got_q.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++)
            check("event", 64'(got_q[base+i]), 64'(exp_q[i]));
        check("frame_err", 64'(err_cnt - e0), 64'(exp_err));
        check("miso", 64'(mi0), 64'(exp_miso));
    endtask

    initial begin
        vec_t vt[7];
        bq_t q;
        logic [7:0] mi;
        int b0, e0, r, nf, op;
        vt[0] = '{112'h01FD01312D0064, 7, -1, 1, 0, 8'hFD, 32'h01312D00, 8'h64, 1'b1, 8'h00};
        vt[1] = '{112'h02FD, 2, -1, 1, 0, 8'hFD, 32'h01312D00, 8'h64, 1'b0, 8'h01};
        vt[2] = '{112'h01070000000122030500001000, 13, -1, 2, 0, 8'h05, 32'h00001000, 8'h22, 1'b1, 8'h02};
        vt[3] = '{112'h0109112233, 5, 3, 0, 1, 8'h05, 32'h00001000, 8'h22, 1'b1, 8'h04};
        vt[4] = '{112'h0205, 2, -1, 1, 0, 8'h05, 32'h00001000, 8'h22, 1'b0, 8'h84};
        vt[5] = '{112'h7F1122334455, 6, -1, 0, 1, 8'h05, 32'h00001000, 8'h22, 1'b0, 8'h05};
        vt[6] = '{112'h020A, 2, -1, 1, 0, 8'h0A, 32'h00001000, 8'h22, 1'b0, 8'h85};
        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        model_reset();
        #21;
        check("rst_dds", 64'(dds), 0);
        check("rst_adsr", 64'(adsr), 0);
        check("rst_voice", 64'(voice), 0);
        check("rst_tune", 64'(tune), 0);
        check("rst_vel", 64'(vel), 0);
        check("rst_ns", 64'(ns), 0);
        check("rst_err", 64'(ferr), 0);
        check("rst_miso", 64'(miso), 0);
        rst_n = 1'b1;
        #(4*HALF);

        for (int i = 0; i < 7; i++) begin
            q.delete();
            for (int k = 0; k < vt[i].n; k++) q.push_back(vt[i].bytes[8*(vt[i].n-1-k) +: 8]);
            b0 = got_q.size();
            e0 = err_cnt;
            run_cs(q, vt[i].cut, mi);
            check("t_events", 64'(got_q.size() - b0), 64'(vt[i].n_ev));
            check("t_err", 64'(err_cnt - e0), 64'(vt[i].n_err));
            check("t_voice", 64'(voice), 64'(vt[i].voice));
            check("t_tune", 64'(tune), 64'(vt[i].tune));
            check("t_vel", 64'(vel), 64'(vt[i].vel));
            check("t_ns", 64'(ns), 64'(vt[i].ns));
            check("t_miso", 64'(mi), 64'(vt[i].miso));
        end

        // Reset in the middle of a NOTE_ON payload
        b0 = got_q.size();
        e0 = err_cnt;
        cs_n = 1'b0;
        #HALF;
        xfer_byte(8'h01, 8, mi);
        xfer_byte(8'h0A, 8, mi);
        xfer_byte(8'h12, 8, mi);
        rst_n = 1'b0;
        #1;
        check("mid_rst_voice", 64'(voice), 0);
        check("mid_rst_tune", 64'(tune), 0);
        check("mid_rst_vel", 64'(vel), 0);
        check("mid_rst_ns", 64'(ns), 0);
        check("mid_rst_miso", 64'(miso), 0);
        #HALF;
        cs_n = 1'b1;
        #HALF;
        rst_n = 1'b1;
        #(4*HALF);
        check("mid_rst_events", 64'(got_q.size() - b0), 0);
        check("mid_rst_err", 64'(err_cnt - e0), 0);
        model_reset();

        // Good-frame counter wrap
        q.delete();
        for (int k = 0; k < 127; k++) begin
            q.push_back(8'h02);
            q.push_back(8'(k));
        end
        run_cs(q, -1, mi);
        run_cs('{8'h02, 8'h01}, -1, mi);
        check("wrap_127", 64'(mi), 64'h7F);
        run_cs('{8'h02, 8'h02}, -1, mi);
        check("wrap_0", 64'(mi), 64'h00);

        for (int it = 0; it < 16; it++) begin
            q.delete();
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) begin
                op = $urandom_range(1, 3);
                q.push_back(8'(op));
                for (int k = 1; k < (op == 1 ? 7 : op == 2 ? 2 : 6); k++) q.push_back(8'($urandom));
            end
            r = $urandom_range(0, 9);
            if (r == 0) begin
                q.push_back(8'($urandom_range(4, 255)));
                q.push_back(8'($urandom));
                q.push_back(8'($urandom));
            end
            if (r == 1) q.pop_back();
            if (r == 2) q.push_back(8'($urandom));
            run_cs(q, r == 2 ? int'($urandom_range(1, 7)) : -1, mi);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
- SPI mode-0 slave that receives note commands from the host MCU and decodes them into the command bus consumed by voice_controller: dds/adsr strobes, voice index, tuning code, velocity and note status.
- It is the source end of that bus; today only a testbench drives it.
- Sits between the board SPI pins and voice_controller, in the i_clk domain.
- Also returns one status byte to the host on MISO.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on i_sclk, i_cs_n and i_mosi (minimum 2)
FRAME_CNT_W, 7, width of the good-frame counter reported in the status byte

Ports:
i_clk  in  1  system clock; must be at least 8x the SCLK frequency
i_reset  in  1  asynchronous, active-low reset
i_sclk  in  1  SPI clock, asynchronous to i_clk
i_cs_n  in  1  SPI chip select, active-low
i_mosi  in  1  SPI data in, MSB first
o_miso  out  1  SPI data out; status byte
o_SPI_flag_dds  out  1  one-cycle strobe: load the tuning code into the DDS
o_SPI_flag_adsr  out  1  one-cycle strobe: gate the ADSR with note status
o_SPI_voice_index  out  8  target voice
o_SPI_tuning_code  out  32  DDS phase increment
o_SPI_velocity  out  8  note velocity
o_SPI_note_status  out  1  1 = note on, 0 = note off
o_frame_err  out  1  one-cycle pulse when a frame is aborted or invalid

Behaviour:
- Reset: all outputs 0; byte counter, bit counter, shift register, frame counter and sticky error all cleared. Reset mid-frame discards the frame and emits no strobe.
- Synchronization: i_sclk, i_cs_n and i_mosi each pass through SYNC_STAGES flops.
- Edge detection: SCLK edges come from the synchronized value XOR its 1-cycle delay.
  - MOSI is sampled on a detected rising edge.
  - MISO is updated on a detected falling edge.
- Framing: a synchronized CS falling edge starts a frame and clears the bit and byte counters. Bytes are MSB first; 8 rising edges make one byte.
- Opcodes (byte 0):
  - 0x01 NOTE_ON, 7 bytes: op, voice, tune[31:24], tune[23:16], tune[15:8], tune[7:0], velocity.
  - 0x02 NOTE_OFF, 2 bytes: op, voice.
  - 0x03 RETUNE, 6 bytes: op, voice, tune (4 bytes).
- Payload staging: payload is held in staging registers. Outputs update only when a frame completes, so a partial frame never changes outputs.
- Frame completion: one i_clk after the cycle in which the final rising edge is detected, outputs are loaded and strobes pulse for exactly 1 cycle, with data valid in the same cycle as the strobe.
  - NOTE_ON: dds=1, adsr=1, note_status=1; voice, tuning and velocity loaded.
  - NOTE_OFF: adsr=1, note_status=0; voice loaded; tuning and velocity hold.
  - RETUNE: dds=1; voice and tuning loaded; note_status and velocity hold.
- Back-to-back frames: after completion the byte counter returns to 0 while CS stays low, so the next byte is a new opcode. Frames may be chained under one CS.
- Unknown opcode: o_frame_err pulses 1 cycle after byte 0 completes. The FSM enters SKIP and ignores all bits until CS rises.
- CS rises mid-frame (partial byte or missing bytes): staging is discarded, o_frame_err pulses, no strobe. CS rising between complete frames is not an error.
- State machine: IDLE (CS high) -> OPCODE (CS fell) -> PAYLOAD (valid opcode) -> DONE (1 cycle, strobes) -> OPCODE.
  - Any state -> IDLE on CS rise.
  - OPCODE -> SKIP on an invalid opcode; SKIP -> IDLE on CS rise.
- Status byte = {err_sticky, good_frame_count[FRAME_CNT_W-1:0]}.
  - Latched at the CS falling edge, shifted MSB first on o_miso during byte 0 of each frame; MSB driven immediately on CS fall.
  - o_miso = 0 outside byte 0 and while CS is high.
  - good_frame_count increments on each DONE and wraps 127 -> 0.
  - err_sticky sets on any o_frame_err and clears when latched into the status byte, unless a new error occurs in the same cycle (set wins).

Decomposition:
- Shared package: opcode constants (OP_NOTE_ON, OP_NOTE_OFF, OP_RETUNE), per-opcode frame lengths, and the FSM state encoding.
- One natural sub-module, spi_sync_edge: a SYNC_STAGES synchronizer plus rise/fall detector, instantiated once per SPI input.

Test Plan:
1. NOTE_ON {01, FD, 01, 31, 2D, 00, 64} -> one cycle with dds=1, adsr=1, voice=253, tuning=32'd20000000, velocity=0x64, note_status=1; o_frame_err stays 0.
2. After test 1, NOTE_OFF {02, FD} -> adsr=1, dds=0, note_status=0, voice=253, tuning still 20000000. The next frame's MISO byte = 0x02.
3. NOTE_ON and RETUNE {03, 05, 00, 00, 10, 00} chained under one CS -> two separate strobe cycles; the second has dds=1, adsr=0, voice=5, tuning=0x1000.
4. CS rises after 3 bits of the 4th NOTE_ON byte -> o_frame_err pulse, no strobes, outputs unchanged. The next frame's MISO byte has MSB=1; the frame after that has MSB=0.
5. Opcode 0x7F followed by 5 bytes -> o_frame_err pulse after byte 0, no strobes. A NOTE_OFF in a new CS frame then decodes correctly.
6. i_reset asserted mid-NOTE_ON payload -> all outputs 0 immediately, no strobe. 128 good frames -> frame count wraps to 0.
